// File: rtl/line_buffer_controller.sv
// Line buffer write controller: counts pixels of a frame and emits write strobes/addresses for an (n-1)-line buffer.
// Write outputs are registered one cycle after acceptance; PixelReady is low outside FILL/STREAM, stalling upstream.
module line_buffer_controller #(
    parameter int AddrWidth   = 3,
    parameter int ImageWidth  = 7,
    parameter int ImageHeight = 5,
    parameter int RowWidth    = 3,
    parameter int WindowSize  = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 PixelValid,
    input  logic                 PixelData,
    output logic                 PixelReady,
    output logic                 WriteEnable,
    output logic [AddrWidth-1:0] Addr,
    output logic                 Data,
    output logic [AddrWidth-1:0] Column,
    output logic [RowWidth-1:0]  Row,
    output logic                 WindowValid,
    output logic                 FrameDone,
    output logic                 Busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [AddrWidth-1:0] LastCol     = AddrWidth'(ImageWidth - 1);
    localparam logic [RowWidth-1:0]  LastRow     = RowWidth'(ImageHeight - 1);
    localparam logic [RowWidth-1:0]  LastFillRow = RowWidth'(WindowSize - 2);
    localparam logic [RowWidth-1:0]  WinRow      = RowWidth'(WindowSize - 1);
    localparam logic [AddrWidth-1:0] WinCol      = AddrWidth'(WindowSize - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AddrWidth-1:0]  r_col;
    logic [AddrWidth-1:0]  w_col_nxt;
    logic [RowWidth-1:0]   r_row;
    logic [RowWidth-1:0]   w_row_nxt;

    logic                  r_we;
    logic [AddrWidth-1:0]  r_addr;
    logic                  r_data;
    logic [RowWidth-1:0]   r_wr_row;
    logic                  r_win_vld;
    logic                  r_frame_done;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_col_end;
    logic                  w_last;
    logic                  w_fill_end;
    logic                  w_in_window;

    assign w_ready     = (r_state == S_FILL) || (r_state == S_STREAM);
    assign w_accept    = PixelValid && w_ready;
    assign w_col_end   = (r_col == LastCol);
    assign w_last      = w_col_end && (r_row == LastRow);
    assign w_fill_end  = w_col_end && (r_row == LastFillRow);
    assign w_in_window = (r_row >= WinRow) && (r_col >= WinCol);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (Start) w_state_nxt = S_FILL;
            // A frame no taller than the fill region can finish straight from FILL.
            S_FILL: begin
                if (w_accept && w_last)          w_state_nxt = S_DONE;
                else if (w_accept && w_fill_end) w_state_nxt = S_STREAM;
            end
            S_STREAM: if (w_accept && w_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (r_state == S_IDLE) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                w_col_nxt = '0;
                // Wrap the row on the final pixel instead of counting past the frame.
                w_row_nxt = w_last ? '0 : r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= 1'b0;
            r_wr_row     <= '0;
            r_win_vld    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_we         <= w_accept;
            r_win_vld    <= w_accept && w_in_window;
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                r_addr   <= r_col;
                r_data   <= PixelData;
                r_wr_row <= r_row;
            end
        end
    end

    assign PixelReady  = w_ready;
    assign WriteEnable = r_we;
    assign Addr        = r_addr;
    assign Column      = r_addr;
    assign Data        = r_data;
    assign Row         = r_wr_row;
    assign WindowValid = r_win_vld;
    assign FrameDone   = r_frame_done;
    assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_line_buffer_controller.sv
// Directed bench for line_buffer_controller with default parameters (7x5 frame, 3x3 window).
module tb_line_buffer_controller;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       PixelValid;
    logic       PixelData;
    logic       PixelReady;
    logic       WriteEnable;
    logic [2:0] Addr;
    logic       Data;
    logic [2:0] Column;
    logic [2:0] Row;
    logic       WindowValid;
    logic       FrameDone;
    logic       Busy;

    int n_cmp;
    int n_bad;

    line_buffer_controller #(
        .AddrWidth  (3),
        .ImageWidth (7),
        .ImageHeight(5),
        .RowWidth   (3),
        .WindowSize (3)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .PixelValid (PixelValid),
        .PixelData  (PixelData),
        .PixelReady (PixelReady),
        .WriteEnable(WriteEnable),
        .Addr       (Addr),
        .Data       (Data),
        .Column     (Column),
        .Row        (Row),
        .WindowValid(WindowValid),
        .FrameDone  (FrameDone),
        .Busy       (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},   32'(WriteEnable), 32'd0);
        chk({tag, "_addr"}, 32'(Addr),        32'd0);
        chk({tag, "_data"}, 32'(Data),        32'd0);
        chk({tag, "_col"},  32'(Column),      32'd0);
        chk({tag, "_row"},  32'(Row),         32'd0);
        chk({tag, "_wv"},   32'(WindowValid), 32'd0);
        chk({tag, "_fd"},   32'(FrameDone),   32'd0);
        chk({tag, "_busy"}, 32'(Busy),        32'd0);
        chk({tag, "_rdy"},  32'(PixelReady),  32'd0);
    endtask

    // First line uses the hand-picked pattern 1,0,1,1,0,0,1; later lines an index-derived bit.
    function automatic logic pix(input int n);
        logic [6:0] pat;
        logic [31:0] nv;
        pat = 7'b1001101;
        nv  = 32'(n);
        if (n < 7) return pat[n];
        return nv[0] ^ nv[1];
    endfunction

    initial begin
        int r;
        int c;
        n_cmp      = 0;
        n_bad      = 0;
        Reset      = 1'b1;
        Start      = 1'b0;
        PixelValid = 1'b0;
        PixelData  = 1'b0;

        tick();
        tick();
        chk_all_zero("rst_held");
        Reset = 1'b0;
        tick();
        chk_all_zero("rst_rel");

        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_busy", 32'(Busy),        32'd1);
        chk("start_rdy",  32'(PixelReady),  32'd1);
        chk("start_we",   32'(WriteEnable), 32'd0);

        // Full continuous 35-pixel frame.
        for (int n = 0; n < 35; n++) begin
            r = n / 7;
            c = n % 7;
            PixelValid = 1'b1;
            PixelData  = pix(n);
            tick();
            chk($sformatf("px%0d_we", n),   32'(WriteEnable), 32'd1);
            chk($sformatf("px%0d_addr", n), 32'(Addr),        32'(c));
            chk($sformatf("px%0d_col", n),  32'(Column),      32'(c));
            chk($sformatf("px%0d_row", n),  32'(Row),         32'(r));
            chk($sformatf("px%0d_data", n), 32'(Data),        32'(pix(n)));
            chk($sformatf("px%0d_wv", n),   32'(WindowValid), 32'((r >= 2 && c >= 2) ? 1 : 0));
            chk($sformatf("px%0d_fd", n),   32'(FrameDone),   32'((n == 34) ? 1 : 0));
        end
        PixelValid = 1'b0;
        chk("done_rdy",  32'(PixelReady), 32'd0);
        chk("done_busy", 32'(Busy),       32'd1);
        tick();
        chk("post_fd",   32'(FrameDone),   32'd0);
        chk("post_we",   32'(WriteEnable), 32'd0);
        chk("post_busy", 32'(Busy),        32'd0);
        chk("post_rdy",  32'(PixelReady),  32'd0);

        // Bubbles: PixelValid 1,0,0,1 with a Start pulse inside the gap.
        Start = 1'b1;
        tick();
        Start      = 1'b0;
        PixelValid = 1'b1;
        PixelData  = 1'b1;
        tick();
        chk("bub0_we",   32'(WriteEnable), 32'd1);
        chk("bub0_addr", 32'(Addr),        32'd0);
        PixelValid = 1'b0;
        PixelData  = 1'b0;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
        chk("bub1_we",   32'(WriteEnable), 32'd0);
        chk("bub1_addr", 32'(Addr),        32'd0);
        chk("bub1_data", 32'(Data),        32'd1);
        chk("bub1_busy", 32'(Busy),        32'd1);
        tick();
        chk("bub2_we",   32'(WriteEnable), 32'd0);
        chk("bub2_rdy",  32'(PixelReady),  32'd1);
        PixelValid = 1'b1;
        PixelData  = 1'b0;
        tick();
        chk("bub3_we",   32'(WriteEnable), 32'd1);
        chk("bub3_addr", 32'(Addr),        32'd1);
        chk("bub3_row",  32'(Row),         32'd0);
        chk("bub3_data", 32'(Data),        32'd0);

        // Continue to row 1 column 3 (9 more pixels), then reset mid-frame.
        PixelData = 1'b1;
        for (int n = 0; n < 9; n++) tick();
        chk("pre_rst_we",   32'(WriteEnable), 32'd1);
        chk("pre_rst_row",  32'(Row),         32'd1);
        chk("pre_rst_addr", 32'(Addr),        32'd3);
        Reset = 1'b1;
        tick();
        chk_all_zero("mid_rst");
        Reset = 1'b0;
        tick();
        chk("idle_we",   32'(WriteEnable), 32'd0);
        chk("idle_busy", 32'(Busy),        32'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart_we", 32'(WriteEnable), 32'd0);
        PixelData = 1'b1;
        tick();
        chk("restart_we1",   32'(WriteEnable), 32'd1);
        chk("restart_addr",  32'(Addr),        32'd0);
        chk("restart_row",   32'(Row),         32'd0);
        chk("restart_data",  32'(Data),        32'd1);
        PixelValid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
